// File: rtl/intc_prio_n.sv
// Priority interrupt controller: NUM_SRC configurable sources plus NMI, arbitrated
// against the CPU mask and presented through a REQ/ACK handshake with a register file.
module intc_prio_n #(
    parameter int                 NUM_SRC = 16,
    parameter int                 LVL_W   = 4,
    parameter int                 VEC_W   = 8,
    parameter int                 NMI_VEC = 11,
    parameter logic [LVL_W-1:0]   NMI_LVL = '1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    input  logic [NUM_SRC-1:0] SRC_IRQ,
    input  logic               NMI,
    input  logic [LVL_W-1:0]   INT_MASK,
    output logic               INT_REQ,
    output logic [LVL_W-1:0]   INT_LVL,
    output logic [VEC_W-1:0]   INT_VEC,
    input  logic               INT_ACK,
    input  logic [7:0]         REG_A,
    input  logic [31:0]        REG_DI,
    output logic [31:0]        REG_DO,
    input  logic               REG_WE,
    input  logic               REG_REQ,
    output logic               REG_ACT
);

    localparam int         IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [5:0] PEND_IDX = 6'h3F;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    logic [NUM_SRC-1:0] cfg_mode, cfg_en;
    logic [LVL_W-1:0]   cfg_prio [NUM_SRC];
    logic [VEC_W-1:0]   cfg_vec  [NUM_SRC];

    logic [NUM_SRC-1:0] irq_q, edge_pend, pend, elig;
    logic [NUM_SRC-1:0] cfg_wr, edge_set, edge_clr;
    logic               nmi_prev, nmi_latch;

    logic [5:0]         word_idx;
    logic               in_cfg, is_pend, wr_en, rd_en;
    logic [31:0]        rd_data;

    logic               any_elig;
    logic [LVL_W-1:0]   best_lvl;
    logic [VEC_W-1:0]   best_vec;
    logic [IDX_W-1:0]   best_id;

    state_t             state, state_nxt;
    logic               req_nxt, win_nmi, win_nmi_nxt, ack_fire;
    logic [LVL_W-1:0]   lvl_nxt;
    logic [VEC_W-1:0]   vec_nxt;
    logic [IDX_W-1:0]   win_id, win_id_nxt;

    assign word_idx = REG_A[7:2];
    assign in_cfg   = 32'(word_idx) < NUM_SRC;
    assign is_pend  = (word_idx == PEND_IDX);
    assign REG_ACT  = in_cfg | is_pend;
    assign wr_en    = CE & REG_REQ & REG_WE;
    assign rd_en    = CE & REG_REQ & ~REG_WE;
    assign ack_fire = CE & (state == S_REQ) & INT_ACK;

    // NOTE: every variable in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cfg_wr   = '0;
        pend     = '0;
        elig     = '0;
        edge_set = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cfg_wr[i]   = wr_en & (word_idx == 6'(i));
            pend[i]     = cfg_mode[i] ? edge_pend[i] : irq_q[i];
            elig[i]     = pend[i] & cfg_en[i] & (cfg_prio[i] != '0) & (cfg_prio[i] > INT_MASK);
            edge_set[i] = cfg_mode[i] & SRC_IRQ[i] & ~irq_q[i];
        end
    end

    always_comb begin
        edge_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            edge_clr[i] = (wr_en & is_pend & REG_DI[i])
                        | (cfg_wr[i] & (REG_DI[16] != cfg_mode[i]))
                        | (ack_fire & ~win_nmi & (win_id == IDX_W'(i)));
        end
    end

    // Strict '>' while scanning upward keeps the lowest index on a priority tie.
    always_comb begin
        any_elig = 1'b0;
        best_lvl = '0;
        best_vec = '0;
        best_id  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i] && (cfg_prio[i] > best_lvl)) begin
                any_elig = 1'b1;
                best_lvl = cfg_prio[i];
                best_vec = cfg_vec[i];
                best_id  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (is_pend) rd_data[NUM_SRC-1:0] = pend;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (word_idx == 6'(i)) begin
                rd_data[16]          = cfg_mode[i];
                rd_data[15]          = cfg_en[i];
                rd_data[LVL_W+7:8]   = cfg_prio[i];
                rd_data[VEC_W-1:0]   = cfg_vec[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_q     <= '0;
            edge_pend <= '0;
            nmi_prev  <= 1'b1;
            nmi_latch <= 1'b0;
            cfg_mode  <= '0;
            cfg_en    <= '0;
            REG_DO    <= '0;
            // NOTE: the config arrays are architecturally visible, so they are reset, not left as plain RAM.
            for (int i = 0; i < NUM_SRC; i++) begin
                cfg_prio[i] <= '0;
                cfg_vec[i]  <= '0;
            end
        end else if (CE) begin
            irq_q     <= SRC_IRQ;
            edge_pend <= (edge_pend & ~edge_clr) | edge_set;
            nmi_prev  <= NMI;
            nmi_latch <= (nmi_latch & ~(ack_fire & win_nmi)) | (NMI & ~nmi_prev);
            if (rd_en) REG_DO <= rd_data;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg_wr[i]) begin
                    cfg_mode[i] <= REG_DI[16];
                    cfg_en[i]   <= REG_DI[15];
                    cfg_prio[i] <= REG_DI[LVL_W+7:8];
                    cfg_vec[i]  <= REG_DI[VEC_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            INT_REQ <= 1'b0;
            INT_LVL <= '0;
            INT_VEC <= '0;
            win_id  <= '0;
            win_nmi <= 1'b0;
        end else if (CE) begin
            state   <= state_nxt;
            INT_REQ <= req_nxt;
            INT_LVL <= lvl_nxt;
            INT_VEC <= vec_nxt;
            win_id  <= win_id_nxt;
            win_nmi <= win_nmi_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_nxt     = INT_REQ;
        lvl_nxt     = INT_LVL;
        vec_nxt     = INT_VEC;
        win_id_nxt  = win_id;
        win_nmi_nxt = win_nmi;
        case (state)
            S_IDLE: begin
                if (nmi_latch) begin
                    req_nxt     = 1'b1;
                    lvl_nxt     = NMI_LVL;
                    vec_nxt     = VEC_W'(NMI_VEC);
                    win_nmi_nxt = 1'b1;
                    state_nxt   = S_REQ;
                end else if (any_elig) begin
                    req_nxt     = 1'b1;
                    lvl_nxt     = best_lvl;
                    vec_nxt     = best_vec;
                    win_id_nxt  = best_id;
                    win_nmi_nxt = 1'b0;
                    state_nxt   = S_REQ;
                end
            end
            S_REQ: begin
                if (INT_ACK) begin
                    req_nxt   = 1'b0;
                    state_nxt = S_HOLD;
                end else if (!win_nmi && !elig[win_id]) begin
                    req_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            S_HOLD:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_intc_prio_n.sv
// Directed self-checking bench for intc_prio_n: arbitration, handshake, NMI,
// pending W1C/mode behaviour, reset and clock enable.
module tb_intc_prio_n;

    localparam int NUM_SRC = 16;
    localparam int LVL_W   = 4;
    localparam int VEC_W   = 8;

    logic               CLK = 1'b0;
    logic               RST, CE, NMI, INT_ACK, REG_WE, REG_REQ;
    logic [NUM_SRC-1:0] SRC_IRQ;
    logic [LVL_W-1:0]   INT_MASK;
    logic               INT_REQ, REG_ACT;
    logic [LVL_W-1:0]   INT_LVL;
    logic [VEC_W-1:0]   INT_VEC;
    logic [7:0]         REG_A;
    logic [31:0]        REG_DI, REG_DO;
    logic [31:0]        rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    intc_prio_n #(.NUM_SRC(NUM_SRC), .LVL_W(LVL_W), .VEC_W(VEC_W)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .SRC_IRQ(SRC_IRQ), .NMI(NMI),
        .INT_MASK(INT_MASK), .INT_REQ(INT_REQ), .INT_LVL(INT_LVL), .INT_VEC(INT_VEC),
        .INT_ACK(INT_ACK), .REG_A(REG_A), .REG_DI(REG_DI), .REG_DO(REG_DO),
        .REG_WE(REG_WE), .REG_REQ(REG_REQ), .REG_ACT(REG_ACT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        REG_A = a; REG_DI = d; REG_WE = 1'b1; REG_REQ = 1'b1;
        tick();
        REG_WE = 1'b0; REG_REQ = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
        REG_A = a; REG_WE = 1'b0; REG_REQ = 1'b1;
        tick();
        REG_REQ = 1'b0;
        d = REG_DO;
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    function automatic logic [31:0] cfg_word(input logic mode, input logic en,
                                             input logic [3:0] prio, input logic [7:0] vec);
        return {15'd0, mode, en, 3'd0, prio, vec};
    endfunction

    initial begin
        RST = 1'b1; CE = 1'b1; NMI = 1'b0; INT_ACK = 1'b0; REG_WE = 1'b0; REG_REQ = 1'b0;
        SRC_IRQ = '0; INT_MASK = '0; REG_A = '0; REG_DI = '0;
        tick(); tick();
        RST = 1'b0;
        check("rst_req", 32'(INT_REQ), 32'd0);
        check("rst_lvl", 32'(INT_LVL), 32'd0);
        check("rst_vec", 32'(INT_VEC), 32'd0);
        check("rst_do",  REG_DO, 32'd0);

        // Address decode
        REG_A = 8'h3C; #1 check("act_3c", 32'(REG_ACT), 32'd1);
        REG_A = 8'h3F; #1 check("act_3f", 32'(REG_ACT), 32'd1);
        REG_A = 8'h40; #1 check("act_40", 32'(REG_ACT), 32'd0);
        REG_A = 8'hFC; #1 check("act_fc", 32'(REG_ACT), 32'd1);

        // Config readback and unused bits
        reg_write(8'h10, 32'hFFFF_FFFF);
        reg_read(8'h10, rd);
        check("cfg4_mask_bits", rd, 32'h0001_8FFF);
        reg_write(8'h10, 32'h0);
        reg_read(8'h44, rd);
        check("unmapped_rd", rd, 32'h0);

        // Level source 3, prio 5, mask 2: request two cycles after the line rises
        INT_MASK = 4'd2;
        reg_write(8'h0C, cfg_word(1'b0, 1'b1, 4'd5, 8'h40));
        reg_read(8'h0C, rd);
        check("cfg3_rd", rd, 32'h0000_8540);
        SRC_IRQ[3] = 1'b1;
        tick();
        check("lvl_t1_req", 32'(INT_REQ), 32'd0);
        tick();
        check("lvl_t2_req", 32'(INT_REQ), 32'd1);
        check("lvl_t2_lvl", 32'(INT_LVL), 32'd5);
        check("lvl_t2_vec", 32'(INT_VEC), 32'h40);

        // Withdrawal when the level drops before ACK
        SRC_IRQ[3] = 1'b0;
        tick(); tick();
        check("withdraw_req", 32'(INT_REQ), 32'd0);
        tick();
        check("withdraw_stay", 32'(INT_REQ), 32'd0);
        SRC_IRQ[3] = 1'b1;
        tick(); tick();
        check("rereq_req", 32'(INT_REQ), 32'd1);
        // ACK does not clear a level source
        ack();
        check("lvl_hold_req", 32'(INT_REQ), 32'd0);
        tick();
        check("lvl_idle_req", 32'(INT_REQ), 32'd0);
        tick();
        check("lvl_again_req", 32'(INT_REQ), 32'd1);
        SRC_IRQ[3] = 1'b0;
        reg_write(8'h0C, 32'h0);
        tick(); tick(); tick();
        check("lvl_clean", 32'(INT_REQ), 32'd0);

        // Tie at prio 9 between edge sources 2 and 7: lowest index first
        reg_write(8'h08, cfg_word(1'b1, 1'b1, 4'd9, 8'h22));
        reg_write(8'h1C, cfg_word(1'b1, 1'b1, 4'd9, 8'h77));
        SRC_IRQ[2] = 1'b1; SRC_IRQ[7] = 1'b1;
        tick();
        SRC_IRQ = '0;
        tick();
        check("tie_req", 32'(INT_REQ), 32'd1);
        check("tie_lvl", 32'(INT_LVL), 32'd9);
        check("tie_vec_first", 32'(INT_VEC), 32'h22);
        reg_read(8'hFC, rd);
        check("tie_pend_both", rd, 32'h0000_0084);
        ack();
        check("tie_hold", 32'(INT_REQ), 32'd0);
        tick(); tick();
        check("tie_second_req", 32'(INT_REQ), 32'd1);
        check("tie_vec_second", 32'(INT_VEC), 32'h77);
        ack();
        tick(); tick();
        check("tie_done_req", 32'(INT_REQ), 32'd0);
        reg_read(8'hFC, rd);
        check("tie_pend_end", rd, 32'h0);

        // Priority equal to mask is masked; lowering the mask releases it
        reg_write(8'h14, cfg_word(1'b0, 1'b1, 4'd3, 8'h55));
        INT_MASK = 4'd3;
        SRC_IRQ[5] = 1'b1;
        tick(); tick(); tick();
        check("mask_eq_req", 32'(INT_REQ), 32'd0);
        INT_MASK = 4'd2;
        tick();
        check("mask_low_req", 32'(INT_REQ), 32'd1);
        check("mask_low_vec", 32'(INT_VEC), 32'h55);
        INT_MASK = 4'd3;
        tick();
        check("mask_raise_withdraw", 32'(INT_REQ), 32'd0);
        SRC_IRQ[5] = 1'b0;
        reg_write(8'h14, 32'h0);
        reg_write(8'h08, 32'h0);
        reg_write(8'h1C, 32'h0);

        // NMI ignores the mask; an edge in the ACK cycle re-latches
        INT_MASK = 4'hF;
        NMI = 1'b1;
        tick();
        NMI = 1'b0;
        tick();
        check("nmi_req", 32'(INT_REQ), 32'd1);
        check("nmi_lvl", 32'(INT_LVL), 32'hF);
        check("nmi_vec", 32'(INT_VEC), 32'd11);
        NMI = 1'b1;
        ack();
        NMI = 1'b0;
        check("nmi_hold", 32'(INT_REQ), 32'd0);
        tick();
        check("nmi_idle", 32'(INT_REQ), 32'd0);
        tick();
        check("nmi_second_req", 32'(INT_REQ), 32'd1);
        check("nmi_second_vec", 32'(INT_VEC), 32'd11);
        ack();
        tick(); tick();
        check("nmi_no_third", 32'(INT_REQ), 32'd0);

        // W1C coinciding with a new edge: set wins
        reg_write(8'h08, cfg_word(1'b1, 1'b1, 4'd9, 8'h22));
        SRC_IRQ[2] = 1'b1; tick(); SRC_IRQ[2] = 1'b0; tick();
        reg_read(8'hFC, rd);
        check("w1c_pend_set", rd, 32'h4);
        SRC_IRQ[2] = 1'b1;
        reg_write(8'hFC, 32'h4);
        SRC_IRQ[2] = 1'b0;
        reg_read(8'hFC, rd);
        check("w1c_vs_edge", rd, 32'h4);
        reg_write(8'hFC, 32'h4);
        reg_read(8'hFC, rd);
        check("w1c_clear", rd, 32'h0);

        // Mode change clears edge-pending
        SRC_IRQ[2] = 1'b1; tick(); SRC_IRQ[2] = 1'b0; tick();
        reg_write(8'h08, cfg_word(1'b0, 1'b1, 4'd9, 8'h22));
        reg_write(8'h08, cfg_word(1'b1, 1'b1, 4'd9, 8'h22));
        reg_read(8'hFC, rd);
        check("mode_chg_clear", rd, 32'h0);

        // Reset mid-REQ, NMI held high through reset must not fire
        INT_MASK = 4'd2;
        SRC_IRQ[2] = 1'b1; tick(); SRC_IRQ[2] = 1'b0; tick();
        check("prerst_req", 32'(INT_REQ), 32'd1);
        NMI = 1'b1;
        RST = 1'b1;
        tick();
        check("rst_mid_req", 32'(INT_REQ), 32'd0);
        RST = 1'b0;
        tick();
        reg_read(8'hFC, rd);
        check("rst_pend", rd, 32'h0);
        reg_read(8'h08, rd);
        check("rst_cfg2", rd, 32'h0);
        tick();
        check("rst_nmi_held", 32'(INT_REQ), 32'd0);
        NMI = 1'b0;

        // Clock enable freezes all state
        reg_write(8'h0C, cfg_word(1'b0, 1'b1, 4'd5, 8'h40));
        CE = 1'b0;
        SRC_IRQ[3] = 1'b1;
        tick(); tick(); tick();
        check("ce_off_req", 32'(INT_REQ), 32'd0);
        CE = 1'b1;
        tick();
        check("ce_on_t1", 32'(INT_REQ), 32'd0);
        tick();
        check("ce_on_t2", 32'(INT_REQ), 32'd1);
        check("ce_on_vec", 32'(INT_VEC), 32'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
